dmem_arbiter: RTL and testbench

//  Two-port arbiter/sequencer for the single-port data memory dm. Port 0 (core load/store unit)
//  and port 1 (debug/DMA loader) issue byte-addressed, sized requests. The block grants one,

---
 rtl/dmem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port request arbiter and sequencer for data memory dm.
// DMARB_ROUND_ROBIN_EN selects round-robin, else fixed port-0 priority.
module dmem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [1:0]        p0_size,
  input  logic              p0_uns,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [1:0]        p1_size,
  input  logic              p1_uns,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [2:0]        dm_DMWr,
  output logic [ADDR_W-3:0] dm_addr,
  output logic [1:0]        dm_sign,
  output logic [DATA_W-1:0] dm_din,
  input  logic [DATA_W-1:0] dm_dout,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic              any_req;
  logic              win;
  logic              l_own;
  logic              l_we;
  logic              l_uns;
  logic [1:0]        l_size;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic [DATA_W-1:0] ld_ext;

  assign any_req = p0_req | p1_req;
  assign busy    = (state != IDLE);

`ifdef DMARB_ROUND_ROBIN_EN
  logic last;

  // Winner: on a tie, the port that was not granted last.
  always_comb begin
    win = 1'b0;
    if (p0_req && p1_req) win = ~last;
    else                  win = p1_req;
  end

  // Remember the most recent grant for tie-breaking.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                           last <= 1'b1;
    else if (state == IDLE && any_req)   last <= win;
  end
`else
  // Winner: port 0 always beats port 1.
  always_comb begin
    win = 1'b0;
    win = p1_req & ~p0_req;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state: one access every three cycles.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Latch the winning request at grant time.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      l_own   <= 1'b0;
      l_we    <= 1'b0;
      l_uns   <= 1'b0;
      l_size  <= 2'b00;
      l_addr  <= '0;
      l_wdata <= '0;
    end else if (state == IDLE && any_req) begin
      l_own   <= win;
      l_we    <= win ? p1_we    : p0_we;
      l_uns   <= win ? p1_uns   : p0_uns;
      l_size  <= win ? p1_size  : p0_size;
      l_addr  <= win ? p1_addr  : p0_addr;
      l_wdata <= win ? p1_wdata : p0_wdata;
    end
  end

  // Sign/zero extension of the aligned dm read data.
  always_comb begin
    ld_ext = dm_dout;
    unique case (l_size)
      2'b00: ld_ext = {{(DATA_W-8){dm_dout[7] & ~l_uns}},
                       dm_dout[7:0]};
      2'b01: ld_ext = {{(DATA_W-16){dm_dout[15] & ~l_uns}},
                       dm_dout[15:0]};
      default: ld_ext = dm_dout;
    endcase
  end

  // Capture load data for the owner at the end of the access cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else if (state == ACCESS && !l_we) begin
      if (l_own) p1_rdata <= ld_ext;
      else       p0_rdata <= ld_ext;
    end
  end

  // Grants, responses and dm controls decoded from state.
  always_comb begin
    p0_gnt    = 1'b0;
    p1_gnt    = 1'b0;
    p0_rvalid = 1'b0;
    p1_rvalid = 1'b0;
    dm_DMWr   = 3'b000;
    dm_addr   = '0;
    dm_sign   = 2'b00;
    dm_din    = '0;
    unique case (state)
      IDLE: begin
        p0_gnt = any_req & ~win;
        p1_gnt = any_req & win;
      end
      ACCESS: begin
        dm_addr = l_addr[ADDR_W-1:2];
        dm_sign = l_addr[1:0];
        dm_din  = l_wdata;
        if (l_we) begin
          unique case (l_size)
            2'b00:   dm_DMWr = 3'b100;
            2'b01:   dm_DMWr = 3'b010;
            default: dm_DMWr = 3'b001;
          endcase
        end
      end
      RESP: begin
        p0_rvalid = ~l_own;
        p1_rvalid = l_own;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a byte-array
// reference memory and a behavioural dm model.
`timescale 1ns/1ps
module tb_dmem_arbiter;
`ifdef DMARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam int LIM = 60;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic req [2];
  logic we [2];
  logic [1:0] sz [2];
  logic uns [2];
  logic [8:0] ad [2];
  logic [31:0] wd [2];
  logic p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, busy;
  logic [31:0] p0_rdata, p1_rdata, dm_din, dm_dout;
  logic [2:0] dm_DMWr;
  logic [6:0] dm_addr;
  logic [1:0] dm_sign;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  dmem_arbiter dut (
    .clk(clk), .rstn(rstn),
    .p0_req(req[0]), .p0_we(we[0]), .p0_size(sz[0]),
    .p0_uns(uns[0]), .p0_addr(ad[0]), .p0_wdata(wd[0]),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(req[1]), .p1_we(we[1]), .p1_size(sz[1]),
    .p1_uns(uns[1]), .p1_addr(ad[1]), .p1_wdata(wd[1]),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .dm_DMWr(dm_DMWr), .dm_addr(dm_addr), .dm_sign(dm_sign),
    .dm_din(dm_din), .dm_dout(dm_dout), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pat(int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // dm: 512 bytes, little-endian, byte-aligned combinational read.
  logic [7:0] dmem [512];
  bit dm_init = 1'b0;
  logic [8:0] ba;
  assign ba = {dm_addr, dm_sign};
  assign dm_dout = {dmem[9'(ba + 9'd3)], dmem[9'(ba + 9'd2)],
                    dmem[9'(ba + 9'd1)], dmem[ba]};

  always @(posedge clk) begin
    if (!dm_init) begin
      for (int i = 0; i < 512; i++) dmem[i] <= pat(i);
      dm_init <= 1'b1;
    end else if (dm_DMWr != 3'b000) begin
      dmem[ba] <= dm_din[7:0];
      if (dm_DMWr != 3'b100) dmem[9'(ba + 9'd1)] <= dm_din[15:8];
      if (dm_DMWr == 3'b001) begin
        dmem[9'(ba + 9'd2)] <= dm_din[23:16];
        dmem[9'(ba + 9'd3)] <= dm_din[31:24];
      end
    end
  end

  // Reference model: byte memory plus per-port last load value.
  logic [7:0] gmem [512];
  bit g_init = 1'b0;
  logic [31:0] lrd [2];

  typedef struct {
    int t;
    int own;
    logic we;
    logic [1:0] sz;
    logic [8:0] a;
    logic [31:0] d;
    logic [31:0] rd;
  } ent_t;
  ent_t q[$];
  int nxt_idle = 0;
  int last = 1;

  function automatic int nbytes(logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] gload(logic [8:0] a, logic [1:0] s,
                                        logic u);
    int n;
    logic [31:0] v;
    n = nbytes(s);
    v = 32'h0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = gmem[9'(a + 9'(i))];
    if (!u && n < 4 && v[8*n-1])
      for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic void gstore(logic [8:0] a, logic [1:0] s,
                                 logic [31:0] d);
    for (int i = 0; i < nbytes(s); i++)
      gmem[9'(a + 9'(i))] = d[8*i +: 8];
  endfunction

  // Monitor: grant prediction, access controls, responses, data.
  always @(negedge clk) begin : mon
    ent_t e;
    int w;
    logic [1:0] eg;
    logic [1:0] erv;
    logic ebusy;
    logic [2:0] ewr;
    if (!rstn) begin
      if (!g_init) begin
        for (int i = 0; i < 512; i++) gmem[i] = pat(i);
        g_init = 1'b1;
      end
      chk("reset_ctl",
          {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, busy,
           dm_DMWr, dm_addr, dm_sign}, 64'h0);
      chk("reset_rdata", {p1_rdata, p0_rdata}, 64'h0);
      chk("reset_din", dm_din, 64'h0);
      q.delete();
      nxt_idle = cyc;
      last = 1;
      lrd[0] = 32'h0;
      lrd[1] = 32'h0;
    end else begin
      ebusy = (q.size() > 0) && (cyc > q[0].t);
      chk("busy", busy, ebusy);
      if (q.size() > 0 && cyc == q[0].t + 1) begin
        e = q[0];
        ewr = 3'b000;
        if (e.we)
          ewr = (e.sz == 2'd0) ? 3'b100 :
                (e.sz == 2'd1) ? 3'b010 : 3'b001;
        chk("dm_ctl", {dm_DMWr, dm_addr, dm_sign}, {ewr, e.a});
        chk("dm_din", dm_din, e.d);
      end else begin
        chk("dm_quiet", {dm_DMWr, dm_addr, dm_sign, dm_din}, 64'h0);
      end
      erv = 2'b00;
      if (q.size() > 0 && cyc == q[0].t + 2) begin
        e = q.pop_front();
        erv[e.own] = 1'b1;
        if (e.we) gstore(e.a, e.sz, e.d);
        else      lrd[e.own] = e.rd;
      end
      chk("rvalid", {p1_rvalid, p0_rvalid}, erv);
      chk("rdata", {p1_rdata, p0_rdata}, {lrd[1], lrd[0]});
      eg = 2'b00;
      if (cyc >= nxt_idle && (req[0] || req[1])) begin
        if (req[0] && req[1]) w = RR ? 1 - last : 0;
        else                  w = req[1] ? 1 : 0;
        eg[w] = 1'b1;
        e.t = cyc;
        e.own = w;
        e.we = we[w];
        e.sz = sz[w];
        e.a = ad[w];
        e.d = wd[w];
        e.rd = we[w] ? 32'h0 : gload(ad[w], sz[w], uns[w]);
        q.push_back(e);
        nxt_idle = cyc + 3;
        last = w;
      end
      chk("gnt", {p1_gnt, p0_gnt}, eg);
    end
  end

  task automatic issue(input int p, input logic w, input logic [1:0] s,
                       input logic u, input logic [8:0] a,
                       input logic [31:0] d, input int lim);
    int n;
    logic g;
    n = 0;
    @(posedge clk); #1;
    we[p] = w; sz[p] = s; uns[p] = u; ad[p] = a; wd[p] = d;
    req[p] = 1'b1;
    do begin
      @(negedge clk);
      n++;
      g = p ? p1_gnt : p0_gnt;
    end while (!g && n < lim);
    checks++;
    if (!g) begin
      errors++;
      $display("FAIL gnt_timeout port %0d: no grant in %0d cycles, required within %0d",
               p, n, lim);
    end
    @(posedge clk); #1;
    req[p] = 1'b0;
    we[p] = 1'($urandom);
    ad[p] = 9'($urandom);
    wd[p] = $urandom;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic rnd_port(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      issue(p, 1'($urandom), 2'($urandom), 1'($urandom),
            9'($urandom), $urandom, 400);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; sz[i] = 2'd0;
      uns[i] = 1'b0; ad[i] = 9'h0; wd[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    issue(0, 1'b1, 2'd2, 1'b0, 9'h010, 32'hDEADBEEF, LIM);
    issue(0, 1'b0, 2'd2, 1'b0, 9'h010, 32'h0, LIM);
    settle();
    chk("t1_lw", p0_rdata, 32'hDEADBEEF);

    issue(0, 1'b1, 2'd0, 1'b0, 9'h013, 32'h12345680, LIM);
    issue(0, 1'b0, 2'd0, 1'b0, 9'h013, 32'h0, LIM);
    settle();
    chk("t2_lb", p0_rdata, 32'hFFFFFF80);
    issue(0, 1'b0, 2'd0, 1'b1, 9'h013, 32'h0, LIM);
    settle();
    chk("t2_lbu", p0_rdata, 32'h00000080);

    issue(1, 1'b1, 2'd2, 1'b0, 9'h1FE, 32'h11223344, LIM);
    issue(1, 1'b0, 2'd2, 1'b0, 9'h1FE, 32'h0, LIM);
    settle();
    chk("t3_lw_wrap", p1_rdata, 32'h11223344);
    issue(1, 1'b0, 2'd1, 1'b1, 9'h000, 32'h0, LIM);
    settle();
    chk("t3_word0", p1_rdata, 32'h00001122);

    fork
      for (int k = 0; k < 4; k++)
        issue(0, 1'b1, 2'd2, 1'b0, 9'(9'h100 + 4 * k),
              32'hA0000000 + k, LIM);
      for (int k = 0; k < 4; k++)
        issue(1, 1'b1, 2'd2, 1'b0, 9'(9'h140 + 4 * k),
              32'hB0000000 + k, LIM);
    join
    settle();
    issue(1, 1'b0, 2'd2, 1'b0, 9'h10C, 32'h0, LIM);
    settle();
    chk("t4_readback", p1_rdata, 32'hA0000003);

    issue(0, 1'b1, 2'd2, 1'b0, 9'h020, 32'hCAFEF00D, LIM);
    #1 rstn = 1'b0;
    #1 chk("t5_async", {dm_DMWr, busy}, 4'h0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    issue(0, 1'b0, 2'd2, 1'b0, 9'h020, 32'h0, LIM);
    settle();
    chk("t5_old", p0_rdata,
        {pat(9'h023), pat(9'h022), pat(9'h021), pat(9'h020)});

    issue(1, 1'b1, 2'd2, 1'b0, 9'h004, 32'h80011234, LIM);
    issue(0, 1'b0, 2'd1, 1'b0, 9'h006, 32'h0, LIM);
    settle();
    chk("t6_lh", p0_rdata, 32'hFFFF8001);
    issue(0, 1'b0, 2'd1, 1'b1, 9'h006, 32'h0, LIM);
    settle();
    chk("t6_lhu", p0_rdata, 32'h00008001);

    fork
      rnd_port(0, 60);
      rnd_port(1, 60);
    join
    settle();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
